// File: rtl/syn_forward_stall_ctrl.sv
// syn_forward_stall_ctrl: load-use stall detection and operand forward-select generation.
// Define FWD_STALL_COUNT_EN to build the saturating stall-cycle counter on stall_count.
module syn_forward_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        id_valid,
    input  logic        id_is_load,
    input  logic        id_uses_a,
    input  logic        id_uses_b,
    input  logic        ex_collision_a,
    input  logic        dm_collision_a,
    input  logic        ex_collision_b,
    input  logic        dm_collision_b,
    output logic [1:0]  fwd_sel_a,
    output logic [1:0]  fwd_sel_b,
    output logic        stall,
    output logic        ex_flush,
    output logic [31:0] stall_count
);
    typedef enum logic {RUN, BUBBLE} state_t;
    state_t state, state_nx;
    logic ex_is_load, dm_is_load, stall_a, stall_b;
    always_comb begin
        stall_a   = id_valid & ex_is_load & ex_collision_a & id_uses_a;
        stall_b   = id_valid & ex_is_load & ex_collision_b & id_uses_b;
        stall     = stall_a | stall_b;
        fwd_sel_a = stall_a ? 2'd0 : ex_collision_a ? 2'd1 : dm_collision_a ? 2'd2 : 2'd0;
        fwd_sel_b = stall_b ? 2'd0 : ex_collision_b ? 2'd1 : dm_collision_b ? 2'd2 : 2'd0;
        state_nx  = en ? (stall ? BUBBLE : RUN) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            ex_flush   <= 1'b0;
            ex_is_load <= 1'b0;
            dm_is_load <= 1'b0;
        end else if (en) begin
            state      <= state_nx;
            ex_flush   <= state_nx == BUBBLE;
            ex_is_load <= ~stall & id_is_load & id_valid;
            dm_is_load <= ex_is_load;
        end
    end
    // A bubble always follows a load that has just moved from EX into DM.
    assert property (@(posedge clk) disable iff (rst) state == BUBBLE |-> dm_is_load && !ex_is_load);
`ifdef FWD_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (en && stall && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_syn_forward_stall_ctrl.sv
// tb_syn_forward_stall_ctrl: directed vectors with a scoreboard queue checked at each falling edge.
module tb_syn_forward_stall_ctrl;
    logic clk = 1'b0;
    logic rst, en, id_valid, id_is_load, id_uses_a, id_uses_b;
    logic ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic stall, ex_flush;
    logic [31:0] stall_count;
    int checks = 0, failures = 0;
`ifdef FWD_STALL_COUNT_EN
    localparam logic [31:0] C = 32'd1;
`else
    localparam logic [31:0] C = 32'd0;
`endif
    typedef struct {
        string       name;
        logic [1:0]  a, b;
        logic        st, fl;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    syn_forward_stall_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .id_valid(id_valid), .id_is_load(id_is_load),
        .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
        .ex_collision_a(ex_collision_a), .dm_collision_a(dm_collision_a),
        .ex_collision_b(ex_collision_b), .dm_collision_b(dm_collision_b),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall),
        .ex_flush(ex_flush), .stall_count(stall_count)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (fwd_sel_a !== e.a || fwd_sel_b !== e.b || stall !== e.st || ex_flush !== e.fl || stall_count !== e.cnt) begin
                failures++;
                $display("FAIL %s: got a=%0d b=%0d stall=%0b flush=%0b cnt=%0d, expected a=%0d b=%0d stall=%0b flush=%0b cnt=%0d",
                         e.name, fwd_sel_a, fwd_sel_b, stall, ex_flush, stall_count, e.a, e.b, e.st, e.fl, e.cnt);
            end
        end
    end
    task automatic cyc(input string nm, input logic [9:0] iv, input logic [1:0] a, input logic [1:0] b,
                       input logic st, input logic fl, input logic [31:0] cnt);
        {rst, en, id_valid, id_is_load, id_uses_a, id_uses_b,
         ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b} = iv;
        q.push_back('{nm, a, b, st, fl, cnt});
        @(posedge clk);
        #1;
    endtask
    initial begin
        {rst, en, id_valid, id_is_load, id_uses_a, id_uses_b} = 6'b100000;
        {ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b} = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        //             r e v l a b xa da xb db
        cyc("reset",      10'b1_1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 0, 0, 0);
        cyc("idle",       10'b0_1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 0, 0, 0);
        cyc("alu_id",     10'b0_1_1_0_0_0_0_0_0_0, 2'd0, 2'd0, 0, 0, 0);
        cyc("alu_fwd_a",  10'b0_1_1_0_1_0_1_0_0_0, 2'd1, 2'd0, 0, 0, 0);
        cyc("ex_dm_pri",  10'b0_1_1_1_1_0_1_1_0_1, 2'd1, 2'd2, 0, 0, 0);
        cyc("load_use_b", 10'b0_1_1_0_0_1_0_0_1_0, 2'd0, 2'd0, 1, 0, 0);
        cyc("bubble_dm",  10'b0_1_1_0_0_1_0_0_0_1, 2'd0, 2'd2, 0, 1, C);
        cyc("load_id",    10'b0_1_1_1_0_0_0_0_0_0, 2'd0, 2'd0, 0, 0, C);
        for (int i = 0; i < 3; i++)
            cyc("en_low_stall", 10'b0_0_1_0_1_0_1_1_0_0, 2'd0, 2'd0, 1, 0, C);
        cyc("en_back",    10'b0_1_1_0_1_0_1_1_0_0, 2'd0, 2'd0, 1, 0, C);
        cyc("rst_bubble", 10'b1_1_1_0_1_0_0_1_0_0, 2'd2, 2'd0, 0, 1, 2 * C);
        cyc("post_rst",   10'b0_1_1_1_0_0_0_0_0_0, 2'd0, 2'd0, 0, 0, 0);
        cyc("rst_stall",  10'b1_1_1_0_1_0_1_0_0_0, 2'd0, 2'd0, 1, 0, 0);
        cyc("after_rst",  10'b0_1_1_0_1_0_1_0_0_0, 2'd1, 2'd0, 0, 0, 0);
        cyc("load_id2",   10'b0_1_1_1_0_0_0_0_0_0, 2'd0, 2'd0, 0, 0, 0);
        cyc("invalid_id", 10'b0_1_0_0_1_0_1_0_0_0, 2'd1, 2'd0, 0, 0, 0);
        cyc("dm_load",    10'b0_1_1_0_1_0_0_1_0_0, 2'd2, 2'd0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/syn_forward_stall_ctrl.md
# syn_forward_stall_ctrl

Hazard-resolution stage that consumes the four per-operand collision flags from the synchronous data-collision detector and turns them into operand-forwarding selects and a load-use stall. It tracks whether the instructions in the EX and DM stages are loads, using the same hold/bubble/advance rules as the detector. Its `stall` output drives the detector's `stalled` input, the PC/IF-ID hold enables and the ID/EX bubble insertion. It sits in the ID stage beside the register file read ports.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  **one clock; reset is synchronous and active-high.**
- `en`  in  1  global pipeline enable; 0 freezes all state.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_is_load`  in  1  ID instruction is a load (LW/LB/LH/...).
- `id_uses_a`, `id_uses_b`  in  1 each  ID instruction reads operand A/B in EX.
- `ex_collision_a`, `dm_collision_a`, `ex_collision_b`, `dm_collision_b`  in  1 each  collision flags from the detector.
- `fwd_sel_a`, `fwd_sel_b`  out  2  operand mux select:
  - 0 = regfile
  - 1 = EX ALU result
  - 2 = DM-stage write-back value (ALU result or load data)
  - 3 never driven.
- `stall`  out  1  load-use stall; holds PC and IF/ID, bubbles ID/EX.
- `ex_flush`  out  1  registered; high in the cycle when a bubble occupies EX.
- `stall_count`  out  32  stall-cycle counter (see Configuration).

## Operation
- Internal registers: `ex_is_load`, `dm_is_load`, FSM state, `ex_flush`, counter.
- Register update, in priority order:
  - `rst`: everything clears to 0.
  - `!en`: everything holds.
  - `stall`: `ex_is_load` <= 0, `dm_is_load` <= `ex_is_load`.
  - Otherwise: `ex_is_load` <= `id_is_load & id_valid`, `dm_is_load` <= `ex_is_load`.
- Stall (combinational): `stall = id_valid & ex_is_load & ((ex_collision_a & id_uses_a) | (ex_collision_b & id_uses_b))`.
- Forward select per operand X (combinational):
  - `ex_collision_X` and not stalling → 1.
  - Else `dm_collision_X` → 2.
  - Else 0.
  - EX has priority over DM because it is the younger producer.
  - While `stall`=1, `fwd_sel_X` is 0 for the operand that caused the stall; the other operand follows the normal rules.
- Collisions on register 0 never arrive; the detector masks them. No extra masking here.
- FSM states:
  - RUN → BUBBLE when `en & stall`.
  - BUBBLE → RUN when `en & !stall`; stays in BUBBLE when `en & stall`.
  - `!en` holds the state.
- `ex_flush` = 1 exactly while in BUBBLE; reset value 0.
- Because a bubble clears `ex_is_load`, a single load-use hazard stalls for exactly one cycle. Back-to-back BUBBLE is only possible through a fresh hazard.

## Timing
- `fwd_sel_*` and `stall` are combinational from inputs and registered state in the same cycle, with zero latency.
- `ex_flush` is one register stage, asserted the cycle after `stall` was sampled high with `en`=1.
- Reset values: `fwd_sel_a` = `fwd_sel_b` = 0, `stall` = 0 (because `ex_is_load` = 0), `ex_flush` = 0, `stall_count` = 0, state RUN.
- Reset asserted mid-stall: the next edge forces RUN and clears all flags. `stall` drops in the same cycle once the registers clear.
- `en`=0 while `stall`=1: `stall` remains asserted and no state changes. The counter does not increment.
- Load in DM colliding with ID (`dm_is_load` with `dm_collision`): no stall, `fwd_sel` = 2.

## Configuration
- `FWD_STALL_COUNT_EN` defined:
  - `stall_count` increments by 1 on every edge where `en & stall & !rst`.
  - It saturates at 32'hFFFF_FFFF and clears on `rst`.
- Not defined: `stall_count` is tied to 0 and no counter flops are built.

## Test plan
- Reset, then `en`=1 with all collisions 0 → `fwd_sel_a`=`fwd_sel_b`=0, `stall`=0, `ex_flush`=0, `stall_count`=0.
- ALU instruction (`id_is_load`=0) followed by a consumer with `ex_collision_a`=1, `id_uses_a`=1 → `fwd_sel_a`=1, `stall`=0.
- Load followed by a consumer with `ex_collision_b`=1, `id_uses_b`=1:
  - First cycle: `stall`=1, `fwd_sel_b`=0.
  - Next cycle: `ex_flush`=1 and `stall`=0.
  - With the detector now reporting `dm_collision_b`=1: `fwd_sel_b`=2.
  - `stall_count`=1 with the macro, 0 without.
- `ex_collision_a`=1 and `dm_collision_a`=1 together, with an ALU producer in EX → `fwd_sel_a`=1.
- Load-use stall with `en` dropped for 3 cycles → `stall` stays 1, state and `stall_count` unchanged. When `en` returns, exactly one bubble is inserted.
- `rst`=1 asserted while in BUBBLE → next cycle RUN, `ex_flush`=0, `stall`=0, `stall_count`=0.
